// File: rtl/uart_program_rom.sv
// rtl/uart_program_rom.sv - 16x8 fetch ROM for the tiny CPU, reloadable over UART 8N1
module uart_program_rom #(
    parameter int       CLKS_PER_BIT = 868,
    parameter int       TIMEOUT_CLKS = 1000000,
    parameter bit [7:0] HDR_BYTE     = 8'hA5
) (
    input  logic       clock,
    input  logic       reset_p,
    input  logic       uart_rx,
    input  logic [3:0] address,
    output logic [7:0] rom_data,
    output logic       cpu_hold,
    output logic       load_err,
    output logic       load_done
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_WAIT_HDR, LD_LOAD, LD_CHECK} ld_state_t;

    function automatic logic [7:0] reset_image(input logic [3:0] idx);
        case (idx)
            4'd0:    reset_image = 8'h81;
            4'd1:    reset_image = 8'h82;
            4'd2:    reset_image = 8'h84;
            4'd3:    reset_image = 8'h88;
            4'd4:    reset_image = 8'h84;
            4'd5:    reset_image = 8'h82;
            4'd6:    reset_image = 8'hA0;
            default: reset_image = 8'h00;
        endcase
    endfunction

    logic [7:0]  mem [16];

    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    rx_state_t   rx_state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        frame_err;

    ld_state_t   ld_state;
    logic [3:0]  wr_idx;
    logic [7:0]  sum;
    logic [TW-1:0] tmo_cnt;

    assign rom_data = mem[address];

    // Two-flop synchronizer plus a delayed copy for start-edge detection.
    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            rx_state  <= RX_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        clk_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (clk_cnt == CW'(HALF - 1)) begin
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_s2, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Partially written bytes stay in memory after an abort; cpu_hold keeps the CPU off them.
    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= reset_image(4'(i));
            end
            ld_state  <= LD_WAIT_HDR;
            wr_idx    <= '0;
            sum       <= '0;
            tmo_cnt   <= '0;
            cpu_hold  <= 1'b0;
            load_err  <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (ld_state)
                LD_WAIT_HDR: begin
                    if (rx_valid && rx_byte == HDR_BYTE) begin
                        cpu_hold <= 1'b1;
                        load_err <= 1'b0;
                        wr_idx   <= '0;
                        sum      <= '0;
                        tmo_cnt  <= '0;
                        ld_state <= LD_LOAD;
                    end
                end
                LD_LOAD, LD_CHECK: begin
                    if (rx_valid) begin
                        tmo_cnt <= '0;
                        if (ld_state == LD_LOAD) begin
                            mem[wr_idx] <= rx_byte;
                            sum         <= sum + rx_byte;
                            wr_idx      <= wr_idx + 1'b1;
                            if (wr_idx == 4'd15) begin
                                ld_state <= LD_CHECK;
                            end
                        end else begin
                            ld_state <= LD_WAIT_HDR;
                            if (rx_byte == sum) begin
                                cpu_hold  <= 1'b0;
                                load_done <= 1'b1;
                            end else begin
                                load_err <= 1'b1;
                            end
                        end
                    end else if (frame_err || tmo_cnt == TW'(TIMEOUT_CLKS)) begin
                        load_err <= 1'b1;
                        ld_state <= LD_WAIT_HDR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ld_state <= LD_WAIT_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_rom.sv
// tb/tb_uart_program_rom.sv - directed bench for uart_program_rom at 8 clocks per bit
module tb_uart_program_rom;

    logic       clock;
    logic       reset_p;
    logic       uart_rx;
    logic [3:0] address;
    logic [7:0] rom_data;
    logic       cpu_hold;
    logic       load_err;
    logic       load_done;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic hold_prev = 1'b0;
    logic hold_at_done = 1'b1;
    logic hold_before_done = 1'b0;

    uart_program_rom #(
        .CLKS_PER_BIT(8),
        .TIMEOUT_CLKS(200),
        .HDR_BYTE(8'hA5)
    ) dut (
        .clock    (clock),
        .reset_p  (reset_p),
        .uart_rx  (uart_rx),
        .address  (address),
        .rom_data (rom_data),
        .cpu_hold (cpu_hold),
        .load_err (load_err),
        .load_done(load_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (load_done) begin
            done_cnt         <= done_cnt + 1;
            hold_at_done     <= cpu_hold;
            hold_before_done <= hold_prev;
        end
        hold_prev <= cpu_hold;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_rom(input int idx, input logic [7:0] expected);
        address = 4'(idx);
        #1;
        check($sformatf("rom[%0d]", idx), 32'(rom_data), 32'(expected));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (8) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (8) @(posedge clock);
        end
        uart_rx = stop_bit;
        repeat (8) @(posedge clock);
        uart_rx = 1'b1;
        repeat (4) @(posedge clock);
    endtask

    task automatic glitch();
        uart_rx = 1'b0;
        repeat (2) @(posedge clock);
        uart_rx = 1'b1;
        repeat (20) @(posedge clock);
    endtask

    task automatic send_load(input logic [7:0] base, input logic [7:0] step,
                             input logic [7:0] cs, input logic with_glitch);
        send_byte(8'hA5, 1'b1);
        if (with_glitch) glitch();
        for (int i = 0; i < 16; i++) begin
            send_byte(base + 8'(i) * step, 1'b1);
        end
        send_byte(cs, 1'b1);
        @(negedge clock);
    endtask

    initial begin
        reset_p = 1'b1;
        uart_rx = 1'b1;
        address = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_p = 1'b0;
        repeat (20) @(negedge clock);

        check("reset cpu_hold", 32'(cpu_hold), 32'd0);
        check("reset load_err", 32'(load_err), 32'd0);
        check("reset load_done", 32'(load_done), 32'd0);
        check_rom(0, 8'h81); check_rom(1, 8'h82); check_rom(2, 8'h84); check_rom(3, 8'h88);
        check_rom(4, 8'h84); check_rom(5, 8'h82); check_rom(6, 8'hA0);
        for (int i = 7; i < 16; i++) check_rom(i, 8'h00);

        // Good load: 10..1F sums to 0x178, checksum 0x78.
        send_byte(8'hA5, 1'b1);
        @(negedge clock);
        check("hdr cpu_hold", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b1);
        check("pre-cs cpu_hold", 32'(cpu_hold), 32'd1);
        check("pre-cs done_cnt", 32'(done_cnt), 32'd0);
        send_byte(8'h78, 1'b1);
        @(negedge clock);
        check("good cpu_hold", 32'(cpu_hold), 32'd0);
        check("good load_err", 32'(load_err), 32'd0);
        check("good done_cnt", 32'(done_cnt), 32'd1);
        check("hold at done", 32'(hold_at_done), 32'd0);
        check("hold before done", 32'(hold_before_done), 32'd1);
        for (int i = 0; i < 16; i++) check_rom(i, 8'h10 + 8'(i));

        // Bad checksum, then a good load of 00,11..FF (sum 0x7F8) with a glitch inside.
        send_load(8'h10, 8'h01, 8'h79, 1'b0);
        check("badcs load_err", 32'(load_err), 32'd1);
        check("badcs cpu_hold", 32'(cpu_hold), 32'd1);
        check("badcs done_cnt", 32'(done_cnt), 32'd1);
        send_load(8'h00, 8'h11, 8'hF8, 1'b1);
        check("recover load_err", 32'(load_err), 32'd0);
        check("recover cpu_hold", 32'(cpu_hold), 32'd0);
        check("recover done_cnt", 32'(done_cnt), 32'd2);
        check_rom(5, 8'h55);
        check_rom(15, 8'hFF);

        // Noise in WAIT_HDR.
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        @(negedge clock);
        check("noise cpu_hold", 32'(cpu_hold), 32'd0);
        check("noise load_err", 32'(load_err), 32'd0);
        check("noise done_cnt", 32'(done_cnt), 32'd2);
        check_rom(0, 8'h00);

        // Framing error during load, then a byte that must be ignored.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b0);
        repeat (8) @(posedge clock);
        @(negedge clock);
        check("frame load_err", 32'(load_err), 32'd1);
        check("frame cpu_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h3C, 1'b1);
        @(negedge clock);
        check("after-frame load_err", 32'(load_err), 32'd1);
        check("after-frame cpu_hold", 32'(cpu_hold), 32'd1);
        check_rom(0, 8'h00);

        // Timeout after header plus three bytes.
        send_byte(8'hA5, 1'b1);
        @(negedge clock);
        check("tmo hdr load_err", 32'(load_err), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (150) @(negedge clock);
        check("tmo early load_err", 32'(load_err), 32'd0);
        repeat (110) @(negedge clock);
        check("tmo load_err", 32'(load_err), 32'd1);
        check("tmo cpu_hold", 32'(cpu_hold), 32'd1);
        check_rom(1, 8'h02);
        check_rom(4, 8'h44);

        // Reset in the middle of a byte during a load.
        send_byte(8'hA5, 1'b1);
        uart_rx = 1'b0;
        repeat (20) @(posedge clock);
        #3;
        reset_p = 1'b1;
        #1;
        check("rst cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst load_err", 32'(load_err), 32'd0);
        check("rst load_done", 32'(load_done), 32'd0);
        uart_rx = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_p = 1'b0;
        repeat (4) @(negedge clock);
        check_rom(0, 8'h81); check_rom(3, 8'h88); check_rom(6, 8'hA0); check_rom(7, 8'h00);
        check_rom(15, 8'h00);
        check("post-rst cpu_hold", 32'(cpu_hold), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
